video_timing_detector: RTL and testbench
========================================

# video_timing_detector

Receive-side counterpart of the HDMI sync generators. Samples incoming active-high hsync, vsync and data-enable signals, recovers per-pixel X/Y coordinates for the overlay datapath, and measures active width, active height and total line length. Locks to the expected resolution only after consecutive matching frames, and flags any timing deviation once locked. Sits between the video input and the overlay mixer.

## Interface

- busWidth, 11: width of all counters and coordinate outputs.
- resHorizontal, 1920: expected active pixels per line.
- resVertical, 1080: expected active lines per frame.
- lockFrames, 2: consecutive matching frames required to lock (1..7).

- clock  in  1  pixel clock; all logic on posedge.
- reset  in  1  synchronous, active-high; overrides all other inputs.
- hSyncIn  in  1  horizontal sync, active high.
- vSyncIn  in  1  vertical sync, active high.
- deIn  in  1  data enable, high during active pixels.
- deOut  out  1  deIn delayed to align with xPos/yPos.
- xPos  out  busWidth  active pixel index within line (0-based).
- yPos  out  busWidth  active line index within frame (0-based).
- lineStart  out  1  one-cycle pulse on first active pixel of a line.
- frameStart  out  1  one-cycle pulse on vsync rising edge.
- lineWidth  out  busWidth  active pixel count of last completed line.
- frameHeight  out  busWidth  active line count of last completed frame.
- lineTotal  out  busWidth  clocks between the last two hsync rising edges.
- locked  out  1  high in LOCKED state.
- timingError  out  1  one-cycle pulse on a mismatch while LOCKED.

## Operation

- Input stage: hSyncIn, vSyncIn and deIn are registered once (s1), then again (s2). Rising and falling edges are detected as s1 versus s2.
- Pixel counter: cleared on a DE rising edge and incremented each DE-high cycle. It saturates at 2^busWidth-1.
  - On a DE falling edge, lineWidth takes the count and the line counter increments (saturating).
- Line counter: on a vsync rising edge, frameHeight takes the line count, the line counter clears and frameStart pulses.
- hsync counter: free-running. On an hsync rising edge, lineTotal takes (count+1) and the counter clears. It saturates.
- xPos equals the pixel counter for the current DE-high pixel. yPos equals the line counter.
  - Outside DE, xPos holds its last value and yPos holds the current line count.
- Lock FSM states are SEARCH, VERIFY and LOCKED. A lineBad flag sets on any completed line whose width differs from resHorizontal. It clears at each vsync rising edge.
  - SEARCH: on the first vsync rising edge, go to VERIFY with goodCnt=0. Partial frames are never judged.
  - VERIFY: on each vsync rising edge, the frame is good if lineBad=0 and the line count equals resVertical.
    - Good frame: goodCnt increments. When goodCnt reaches lockFrames, go to LOCKED.
    - Bad frame: goodCnt clears and the FSM stays in VERIFY.
  - LOCKED: any of these events pulses timingError, clears goodCnt and moves to VERIFY.
    - A line completes with width not equal to resHorizontal.
    - The line count exceeds resVertical.
    - A vsync rising edge arrives with line count not equal to resVertical.
  - Only one timingError pulse is produced per LOCKED exit.
- DE falling edge and vsync rising edge in the same cycle: the line is counted into the closing frame first, then the frame is judged and closed.
- Reset clears the following:
  - all counters and s1/s2;
  - deOut, xPos, yPos, lineStart, frameStart, lineWidth, frameHeight, lineTotal, locked and timingError, all to 0;
  - the FSM, to SEARCH.
- Reset mid-frame discards that frame. Relocking needs a full vsync-to-vsync frame after the first vsync.

## Timing

- deIn to deOut latency is 2 clocks. xPos, yPos and lineStart are registered and aligned with deOut.
- vSyncIn rising to frameStart: 2 clocks. frameHeight updates in the same cycle as frameStart.
- deIn falling to lineWidth update: 2 clocks.
- locked asserts in the frameStart cycle of the lockFrames-th good frame.
- locked deasserts, and timingError pulses, 2 clocks after the offending input edge.
- lineTotal updates 2 clocks after the hSyncIn rising edge.

## Test plan

- Reset, then feed three 1920x1080 frames: locked stays 0 through frameStart #2 and rises at frameStart #3; frameHeight=1080 and lineWidth=1920.
- Feed a locked stream, then one 1919-pixel line: timingError is a single pulse 2 clocks after DE falls, locked drops, and relock occurs after 2 further good frames.
- Feed a locked stream, then a frame of 1081 lines: timingError pulses at the 1081st DE falling edge, and frameHeight=1081 at the next frameStart.
- Within a line, check xPos runs 0..1919 with deOut; lineStart is high only at xPos=0; yPos runs 0..1079 across the frame.
- Use hsync with a 2200-clock period: lineTotal=2200. Apply DE fall and vsync rise in the same cycle: that line counts toward the closing frame, so frameHeight=1080.
- Assert reset mid-frame while LOCKED: all outputs are 0 on the next clock, the FSM is in SEARCH, and the following partial frame is not judged.

Source files
------------

// File: rtl/video_timing_detector.sv
// Receive-side video timing recovery: pixel/line coordinates, line and frame
// measurements, and a frame-level lock detector with timing-error reporting.
module video_timing_detector #(
   parameter int busWidth      = 11,
   parameter int resHorizontal = 1920,
   parameter int resVertical   = 1080,
   parameter int lockFrames    = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                hSyncIn,
   input  logic                vSyncIn,
   input  logic                deIn,
   output logic                deOut,
   output logic [busWidth-1:0] xPos,
   output logic [busWidth-1:0] yPos,
   output logic                lineStart,
   output logic                frameStart,
   output logic [busWidth-1:0] lineWidth,
   output logic [busWidth-1:0] frameHeight,
   output logic [busWidth-1:0] lineTotal,
   output logic                locked,
   output logic                timingError
);

   typedef logic [busWidth-1:0] cnt_t;
   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   localparam cnt_t       RES_H  = cnt_t'(resHorizontal);
   localparam cnt_t       RES_V  = cnt_t'(resVertical);
   localparam logic [2:0] LOCK_N = 3'(lockFrames);

   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == '1) ? v : v + cnt_t'(1);
   endfunction

   logic   hs_p1, vs_p1, de_p1;
   logic   hs_p2, vs_p2, de_p2;
   logic   de_rise, de_fall, vs_rise, hs_rise;
   cnt_t   pix_cnt, line_cnt, hs_cnt;
   cnt_t   pix_idx, lines_eff;
   logic   line_bad, width_bad, frame_good, lock_err;
   logic [2:0] good_cnt, good_next;
   state_t state;

   assign de_rise = de_p1 & ~de_p2;
   assign de_fall = ~de_p1 & de_p2;
   assign vs_rise = vs_p1 & ~vs_p2;
   assign hs_rise = hs_p1 & ~hs_p2;

   // A line ending in the same cycle as vsync rises belongs to the closing frame.
   always_comb begin
      pix_idx    = de_rise ? '0 : pix_cnt;
      lines_eff  = de_fall ? sat_inc(line_cnt) : line_cnt;
      width_bad  = de_fall && (pix_cnt != RES_H);
      frame_good = !line_bad && !width_bad && (lines_eff == RES_V);
      lock_err   = width_bad || (lines_eff > RES_V) || (vs_rise && (lines_eff != RES_V));
      good_next  = good_cnt + 3'd1;
   end

   // Stage p1/p2: input registers; outputs below are registered from p1 vs p2.
   always_ff @(posedge clock) begin
      if (reset) begin
         {hs_p1, vs_p1, de_p1} <= '0;
         {hs_p2, vs_p2, de_p2} <= '0;
         pix_cnt     <= '0;
         line_cnt    <= '0;
         hs_cnt      <= '0;
         line_bad    <= 1'b0;
         deOut       <= 1'b0;
         xPos        <= '0;
         yPos        <= '0;
         lineStart   <= 1'b0;
         frameStart  <= 1'b0;
         lineWidth   <= '0;
         frameHeight <= '0;
         lineTotal   <= '0;
      end else begin
         {hs_p1, vs_p1, de_p1} <= {hSyncIn, vSyncIn, deIn};
         {hs_p2, vs_p2, de_p2} <= {hs_p1, vs_p1, de_p1};
         deOut      <= de_p1;
         lineStart  <= de_rise;
         frameStart <= vs_rise;
         yPos       <= line_cnt;
         if (de_p1)
            xPos <= pix_idx;
         if (de_rise)
            pix_cnt <= cnt_t'(1);
         else if (de_p1)
            pix_cnt <= sat_inc(pix_cnt);
         if (de_fall)
            lineWidth <= pix_cnt;
         if (vs_rise) begin
            frameHeight <= lines_eff;
            line_cnt    <= '0;
         end else begin
            line_cnt <= lines_eff;
         end
         if (hs_rise) begin
            lineTotal <= sat_inc(hs_cnt);
            hs_cnt    <= '0;
         end else begin
            hs_cnt <= sat_inc(hs_cnt);
         end
         if (vs_rise)
            line_bad <= 1'b0;
         else if (width_bad)
            line_bad <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= SEARCH;
         good_cnt    <= '0;
         locked      <= 1'b0;
         timingError <= 1'b0;
      end else begin
         timingError <= 1'b0;
         case (state)
            SEARCH: begin
               if (vs_rise) begin
                  state    <= VERIFY;
                  good_cnt <= '0;
               end
            end
            VERIFY: begin
               if (vs_rise) begin
                  if (frame_good) begin
                     good_cnt <= good_next;
                     if (good_next == LOCK_N) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     good_cnt <= '0;
                  end
               end
            end
            LOCKED: begin
               if (lock_err) begin
                  state       <= VERIFY;
                  good_cnt    <= '0;
                  locked      <= 1'b0;
                  timingError <= 1'b1;
               end
            end
            default: begin
               state    <= SEARCH;
               good_cnt <= '0;
               locked   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_timing_detector.sv
// Bench for video_timing_detector: scaled-down resolution, randomized frames,
// cycle-level behavioural reference driven from the raw input samples.
module tb_video_timing_detector;

   localparam int BW   = 11;
   localparam int RH   = 16;
   localparam int RV   = 6;
   localparam int LF   = 2;
   localparam int MAXV = (1 << BW) - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          hSyncIn = 1'b0, vSyncIn = 1'b0, deIn = 1'b0;
   logic          deOut, lineStart, frameStart, locked, timingError;
   logic [BW-1:0] xPos, yPos, lineWidth, frameHeight, lineTotal;

   video_timing_detector #(
      .busWidth(BW), .resHorizontal(RH), .resVertical(RV), .lockFrames(LF)
   ) dut (
      .clock(clock), .reset(reset), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn), .deIn(deIn),
      .deOut(deOut), .xPos(xPos), .yPos(yPos), .lineStart(lineStart),
      .frameStart(frameStart), .lineWidth(lineWidth), .frameHeight(frameHeight),
      .lineTotal(lineTotal), .locked(locked), .timingError(timingError)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;
   int te_count = 0;
   int last_fh  = 0;

   // reference model state
   int pv_h, pv_v, pv_d;
   int pix, lines, hcnt, good;
   int mode;              // 0 searching, 1 verifying, 2 locked
   bit lbad;
   bit m_deOut, m_lineStart, m_frameStart, m_locked, m_te;
   int m_xPos, m_yPos, m_lineWidth, m_frameHeight, m_lineTotal;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > MAXV) ? MAXV : x;
   endfunction

   task automatic model_reset();
      pv_h = 0; pv_v = 0; pv_d = 0;
      pix = 0; lines = 0; hcnt = 0; good = 0; mode = 0; lbad = 1'b0;
      m_deOut = 0; m_lineStart = 0; m_frameStart = 0; m_locked = 0; m_te = 0;
      m_xPos = 0; m_yPos = 0; m_lineWidth = 0; m_frameHeight = 0; m_lineTotal = 0;
   endtask

   // One input sample; the resulting outputs appear two clocks after it is applied.
   task automatic model_step(input int h, input int v, input int d);
      bit dr, df, vr, hr, bad_now;
      int closing;
      dr = (d != 0) && (pv_d == 0);
      df = (d == 0) && (pv_d != 0);
      vr = (v != 0) && (pv_v == 0);
      hr = (h != 0) && (pv_h == 0);
      m_deOut = (d != 0);
      m_lineStart = dr;
      m_frameStart = vr;
      m_yPos = lines;
      m_te = 1'b0;
      if (d != 0) m_xPos = dr ? 0 : pix;
      if (dr) pix = 1;
      else if (d != 0) pix = sat(pix + 1);
      closing = df ? sat(lines + 1) : lines;
      bad_now = df && (pix != RH);
      if (df) m_lineWidth = pix;
      if (vr) begin
         m_frameHeight = closing;
         lines = 0;
      end else begin
         lines = closing;
      end
      if (hr) begin
         m_lineTotal = sat(hcnt + 1);
         hcnt = 0;
      end else begin
         hcnt = sat(hcnt + 1);
      end
      if (mode == 0) begin
         if (vr) begin mode = 1; good = 0; end
      end else if (mode == 1) begin
         if (vr) begin
            if (!lbad && !bad_now && closing == RV) begin
               good++;
               if (good == LF) mode = 2;
            end else begin
               good = 0;
            end
         end
      end else begin
         if (bad_now || closing > RV || (vr && closing != RV)) begin
            m_te = 1'b1; mode = 1; good = 0;
         end
      end
      if (vr) lbad = 1'b0;
      else if (bad_now) lbad = 1'b1;
      m_locked = (mode == 2);
      pv_h = h; pv_v = v; pv_d = d;
   endtask

   task automatic tick(input int h, input int v, input int d);
      hSyncIn = (h != 0); vSyncIn = (v != 0); deIn = (d != 0);
      @(posedge clock);
      @(negedge clock);
      chk("deOut", 32'(deOut), 32'(m_deOut));
      chk("xPos", 32'(xPos), 32'(m_xPos));
      chk("yPos", 32'(yPos), 32'(m_yPos));
      chk("lineStart", 32'(lineStart), 32'(m_lineStart));
      chk("frameStart", 32'(frameStart), 32'(m_frameStart));
      chk("lineWidth", 32'(lineWidth), 32'(m_lineWidth));
      chk("frameHeight", 32'(frameHeight), 32'(m_frameHeight));
      chk("lineTotal", 32'(lineTotal), 32'(m_lineTotal));
      chk("locked", 32'(locked), 32'(m_locked));
      chk("timingError", 32'(timingError), 32'(m_te));
      if (timingError) te_count++;
      if (frameStart) last_fh = int'(frameHeight);
      model_step(h, v, d);
   endtask

   task automatic do_reset();
      reset = 1'b1; hSyncIn = 1'b1; vSyncIn = 1'b1; deIn = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("rst_deOut", 32'(deOut), 0);
      chk("rst_xPos", 32'(xPos), 0);
      chk("rst_yPos", 32'(yPos), 0);
      chk("rst_lineStart", 32'(lineStart), 0);
      chk("rst_frameStart", 32'(frameStart), 0);
      chk("rst_lineWidth", 32'(lineWidth), 0);
      chk("rst_frameHeight", 32'(frameHeight), 0);
      chk("rst_lineTotal", 32'(lineTotal), 0);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_timingError", 32'(timingError), 0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0; hSyncIn = 1'b0; vSyncIn = 1'b0; deIn = 1'b0;
      model_reset();
      model_step(0, 0, 0);
   endtask

   task automatic send_lines(input int ht, input int n, input int bad_idx, input int bad_w, input bit tail);
      for (int l = 0; l < n; l++) begin
         int w, off;
         w   = (l == bad_idx) ? bad_w : RH;
         off = 3 + int'($urandom_range(0, 2));
         for (int c = 0; c < ht; c++) begin
            if (tail && l == n - 1 && c >= off + w) break;
            tick((c < 2) ? 1 : 0, 0, (c >= off && c < off + w) ? 1 : 0);
         end
      end
   endtask

   task automatic send_frame(input int ht, input int n, input int bad_idx, input int bad_w, input bit tail);
      for (int c = 0; c < ht; c++) tick((c < 2) ? 1 : 0, (c < 3) ? 1 : 0, 0);
      for (int c = 0; c < ht; c++) tick((c < 2) ? 1 : 0, 0, 0);
      send_lines(ht, n, bad_idx, bad_w, tail);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // lock after three clean frames
      send_frame(28, RV, -1, 0, 0);
      send_frame(28, RV, -1, 0, 0);
      chk("lock_before_fs3", 32'(locked), 0);
      send_frame(28, RV, -1, 0, 0);
      chk("lock_at_fs3", 32'(locked), 1);
      chk("height", 32'(frameHeight), RV);
      chk("width", 32'(lineWidth), RH);
      chk("line_total", 32'(lineTotal), 28);

      // last DE fall coincides with vsync rise
      send_frame(28, RV, -1, 0, 1);
      send_frame(30, RV, -1, 0, 0);
      chk("same_cycle_height", 32'(last_fh), RV);
      chk("same_cycle_locked", 32'(locked), 1);
      chk("line_total_30", 32'(lineTotal), 30);

      // one short line while locked
      te_count = 0;
      send_frame(28, RV, 2, RH - 1, 0);
      chk("short_line_te", 32'(te_count), 1);
      chk("short_line_unlock", 32'(locked), 0);
      send_frame(28, RV, -1, 0, 0);
      send_frame(28, RV, -1, 0, 0);
      chk("relock_early", 32'(locked), 0);
      send_frame(28, RV, -1, 0, 0);
      chk("relock", 32'(locked), 1);
      chk("short_line_single_te", 32'(te_count), 1);

      // one frame with an extra line
      te_count = 0;
      send_frame(28, RV + 1, -1, 0, 0);
      chk("tall_te", 32'(te_count), 1);
      chk("tall_unlock", 32'(locked), 0);
      send_frame(28, RV, -1, 0, 0);
      chk("tall_height", 32'(last_fh), RV + 1);
      send_frame(28, RV, -1, 0, 0);
      send_frame(28, RV, -1, 0, 0);
      chk("tall_relock", 32'(locked), 1);

      // reset in the middle of a locked frame
      send_frame(28, 3, -1, 0, 0);
      do_reset();
      send_lines(28, RV - 3, -1, 0, 0);
      chk("partial_locked", 32'(locked), 0);
      send_frame(28, RV, -1, 0, 0);
      send_frame(28, RV, -1, 0, 0);
      chk("partial_not_judged", 32'(locked), 0);
      send_frame(28, RV, -1, 0, 0);
      chk("post_reset_lock", 32'(locked), 1);

      // randomized frames
      for (int f = 0; f < 40; f++) begin
         int ht, n, bi, bw;
         bit tl;
         ht = 26 + int'($urandom_range(0, 6));
         n  = RV;
         if ($urandom_range(0, 7) == 0) n = RV - 1 + 2 * int'($urandom_range(0, 1));
         bi = -1;
         bw = RH;
         if ($urandom_range(0, 5) == 0) begin
            bi = int'($urandom_range(0, RV - 1));
            bw = RH - 3 + int'($urandom_range(0, 4));
         end
         tl = ($urandom_range(0, 3) == 0);
         send_frame(ht, n, bi, bw, tl);
      end

      // counter saturation: very long DE run with no hsync
      for (int i = 0; i < 2100; i++) tick(0, 0, 1);
      tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
      chk("sat_width", 32'(lineWidth), MAXV);
      tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
      chk("sat_line_total", 32'(lineTotal), MAXV);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
